// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around a single 1-bit full adder
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_sum_d;
    logic             fa_carry_d;

    fulladder u_fa (
        .a_i (ra_q[0]),
        .b_i (rb_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum_d),
        .c_o (fa_carry_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
                    sum_q   <= {fa_sum_d, sum_q[WIDTH-1:1]};
                    ra_q    <= {1'b0, ra_q[WIDTH-1:1]};
                    rb_q    <= {1'b0, rb_q[WIDTH-1:1]};
                    carry_q <= fa_carry_d;
                    cout_q  <= fa_carry_d;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector self-checking bench for serial_adder
module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       c8, c4;
    logic       busy8, done8, cout8;
    logic       busy4, done4, cout4;
    logic [7:0] sum8;
    logic [3:0] sum4;

    int vectors = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(c4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          output int lat, output logic [7:0] rs, output logic rc);
        a8 = ta; b8 = tb; c8 = tc; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb; c8 = ~tc;
        lat = 0;
        while (!done8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rs = sum8;
        rc = cout8;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset8: busy=%b done=%b sum=%h c_out=%b, required all 0", busy8, done8, sum8, cout8);
        end
        vectors++;
        if ({busy4, done4, sum4, cout4} !== 7'h0) begin
            miscompares++;
            $display("FAIL reset4: busy=%b done=%b sum=%h c_out=%b, required all 0", busy4, done4, sum4, cout4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] va [6] = '{8'h00, 8'hFF, 8'hFF, 8'h5A, 8'h01, 8'h7F};
        logic [7:0] vb [6] = '{8'h00, 8'h01, 8'hFF, 8'h3C, 8'h80, 8'h01};
        logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] es [6] = '{8'h00, 8'h00, 8'hFF, 8'h97, 8'h81, 8'h80};
        logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        logic [7:0] rs;
        logic rc;
        for (int i = 0; i < 6; i++) begin
            do_op8(va[i], vb[i], vc[i], lat, rs, rc);
            vectors++;
            if (lat != 8 || rs !== es[i] || rc !== ec[i]) begin
                miscompares++;
                $display("FAIL basic[%0d]: lat=%0d sum=%h c_out=%b, required lat=8 sum=%h c_out=%b",
                         i, lat, rs, rc, es[i], ec[i]);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (sum8 !== es[i] || cout8 !== ec[i] || busy8 !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: sum=%h c_out=%b busy=%b, required sum=%h c_out=%b busy=0",
                         i, sum8, cout8, busy8, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int busy_cnt = 0;
        int done_cnt = 0;
        int k = 0;
        logic [7:0] rs = '0;
        logic rc = 1'b0;
        logic idle_after_done = 1'b0;
        a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        while (busy8 && k < 40) begin
            busy_cnt++;
            if (k == 2) begin a8 = 8'hC3; b8 = 8'h99; c8 = 1'b0; end
            if (k == 3) begin start8 = 1'b1; a8 = 8'h11; end
            if (k == 4) start8 = 1'b0;
            if (done8) begin
                done_cnt++;
                rs = sum8; rc = cout8;
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end
            @(negedge clk);
            k++;
            if (start8 && !done8) begin
                idle_after_done = !busy8;
                start8 = 1'b0;
            end
        end
        vectors++;
        if (rs !== 8'h97 || rc !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_result: sum=%h c_out=%b, required sum=97 c_out=0", rs, rc);
        end
        vectors++;
        if (done_cnt != 1 || busy_cnt != 9) begin
            miscompares++;
            $display("FAIL ignore_timing: done pulses=%0d busy cycles=%0d, required 1 and 9", done_cnt, busy_cnt);
        end
        vectors++;
        if (idle_after_done !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: idle_after=%b busy=%b, required idle_after=1 busy=0",
                     idle_after_done, busy8);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_add;
        int lat;
        logic [7:0] rs;
        logic rc;
        int dseen = 0;
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b done=%b sum=%h c_out=%b, required all 0", busy8, done8, sum8, cout8);
        end
        repeat (6) begin
            @(negedge clk);
            if (done8) dseen++;
        end
        vectors++;
        if (dseen != 0) begin
            miscompares++;
            $display("FAIL mid_reset_done: done pulses=%0d, required 0", dseen);
        end
        rst_n = 1'b1;
        do_op8(8'h01, 8'h02, 1'b0, lat, rs, rc);
        vectors++;
        if (lat != 8 || rs !== 8'h03 || rc !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: lat=%0d sum=%h c_out=%b, required lat=8 sum=03 c_out=0", lat, rs, rc);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int prev = -1;
        int dcnt = 0;
        int bad_gap = 0;
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start8 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8) begin
                dcnt++;
                if (first < 0) first = k;
                if (prev >= 0 && k - prev != 10) bad_gap++;
                prev = k;
                vectors++;
                if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_result@%0d: sum=%h c_out=%b, required sum=00 c_out=1", k, sum8, cout8);
                end
            end
        end
        start8 = 1'b0;
        vectors++;
        if (dcnt != 4 || first != 9 || bad_gap != 0) begin
            miscompares++;
            $display("FAIL b2b_timing: dones=%0d first=%0d bad_gaps=%0d, required 4, 9, 0", dcnt, first, bad_gap);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_exhaustive4;
        logic [4:0] exp;
        int lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); c4 = 1'(ic); start4 = 1'b1;
                    exp = 5'(ia + ib + ic);
                    @(posedge clk);
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
                    lat = 0;
                    while (!done4 && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    vectors++;
                    if (lat != 4 || {cout4, sum4} !== exp || $isunknown({busy4, done4, sum4, cout4})) begin
                        miscompares++;
                        $display("FAIL exh4 a=%h b=%h c=%0d: lat=%0d c_out=%b sum=%h, required lat=4 c_out=%b sum=%h",
                                 ia, ib, ic, lat, cout4, sum4, exp[4], exp[3:0]);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        test_reset;
        test_basic;
        test_ignore_start;
        test_reset_mid_add;
        test_back_to_back;
        test_exhaustive4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
